// File: rtl/io_link_pkg.sv
// Shared types, defaults and helpers for the board-to-board IO link receiver.
package io_link_pkg;

    localparam int unsigned LOCK_COUNT_DEF     = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [1:0] {
        SEARCH,
        LOCKED,
        LOST
    } link_state_t;

    // Zero-extended input keeps the result correct for any width up to 32.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int unsigned i = 0; i < 31; i++) begin
            b[30-i] = b[31-i] ^ g[30-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/io_link_sync.sv
// Parameterised-width two-flop synchroniser, asynchronous active-low reset.
module io_link_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_link_rx.sv
// IO link receiver: resynchronises, validates and lock-tracks the master's step counter.
// Define IO_LINK_RX_GRAY_EN for Gray-coded pins; otherwise binary pins with a stability filter.
module io_link_rx
    import io_link_pkg::*;
#(
    parameter int unsigned CNT_BITS       = 4,
    parameter int unsigned LOCK_COUNT     = LOCK_COUNT_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned ERR_BITS       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CNT_BITS-1:0] cnt_i,
    input  logic                loop_i,
    input  logic                clr_err_i,
    output logic [CNT_BITS-1:0] cnt_o,
    output logic                cnt_valid_o,
    output logic                loop_o,
    output logic                locked_o,
    output logic                lost_o,
    output logic [ERR_BITS-1:0] err_cnt_o
);

    localparam int unsigned          TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0]  ONE   = CNT_BITS'(1);

    logic [CNT_BITS:0]   sync_q;
    logic [CNT_BITS-1:0] cnt_s;
    logic [CNT_BITS-1:0] v;
    logic                stable;

    io_link_sync #(.WIDTH(CNT_BITS + 1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({loop_i, cnt_i}),
        .q     (sync_q)
    );

    assign cnt_s = sync_q[CNT_BITS-1:0];

`ifdef IO_LINK_RX_GRAY_EN
    localparam int unsigned FILL = 2;

    assign v      = CNT_BITS'(gray2bin(32'(cnt_s)));
    assign stable = 1'b1;
`else
    localparam int unsigned FILL = 3;

    logic [CNT_BITS-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= cnt_s;
    end

    // Two equal consecutive samples absorb skew between binary bits.
    assign v      = prev_q;
    assign stable = (cnt_s == prev_q);
`endif

    // Reset-zeroed pipeline contents must not be mistaken for the first real sample.
    logic [FILL-1:0] fill_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_q <= '0;
        else        fill_q <= {fill_q[FILL-2:0], 1'b1};
    end

    logic                primed_q;
    logic [CNT_BITS-1:0] ref_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                v_ok, step, valid_step, invalid_step, timeout;

    assign v_ok         = fill_q[FILL-1] && stable;
    assign step         = v_ok && primed_q && (v != ref_q);
    assign valid_step   = step && (v == ref_q + ONE);
    assign invalid_step = step && !valid_step;
    assign timeout      = (tmo_q == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q    <= 1'b0;
            ref_q       <= '0;
            cnt_o       <= '0;
            cnt_valid_o <= 1'b0;
            tmo_q       <= '0;
            loop_o      <= 1'b0;
        end else begin
            cnt_valid_o <= step;
            loop_o      <= sync_q[CNT_BITS];
            if (v_ok && !primed_q) begin
                primed_q <= 1'b1;
                ref_q    <= v;
            end
            if (step) begin
                ref_q <= v;
                cnt_o <= v;
                tmo_q <= '0;
            end else if (!timeout) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_o <= '0;
        end else if (invalid_step) begin
            if (clr_err_i)            err_cnt_o <= ERR_BITS'(1);
            else if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_BITS'(1);
        end else if (clr_err_i) begin
            err_cnt_o <= '0;
        end
    end

    link_state_t state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [8:0]  run_inc;

    assign run_inc = {1'b0, run_q} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // A step always takes precedence over a coincident timeout.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            SEARCH: begin
                if (valid_step) begin
                    if (run_inc >= 9'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc[7:0];
                    end
                end else if (invalid_step || timeout) begin
                    run_d = '0;
                end
            end
            LOCKED: begin
                if (invalid_step) begin
                    state_d = SEARCH;
                    run_d   = '0;
                end else if (!step && timeout) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                if (valid_step) begin
                    state_d = SEARCH;
                    run_d   = 8'd1;
                end
            end
            default: begin
                state_d = SEARCH;
                run_d   = '0;
            end
        endcase
    end

    assign locked_o = (state_q == LOCKED);
    assign lost_o   = (state_q == LOST);

endmodule
